// File: rtl/ls_ctrl12.sv
// ls_ctrl12: load/store sequencer with alignment check, bounded dm req/ack wait and write-back strobe
module ls_ctrl12 #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 12,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ls_valid,
   input  logic              ls_is_store,
   input  logic [ADDR_W-1:0] alu_result,
   input  logic [DATA_W-1:0] store_data,
   input  logic [4:0]        rd_addr,
   output logic              ls_ready,
   output logic              dm_req,
   output logic              dm_we,
   output logic [ADDR_W-1:0] dm_addr,
   output logic [DATA_W-1:0] dm_wdata,
   input  logic              dm_ack,
   input  logic [DATA_W-1:0] dm_rdata,
   output logic              wb_en,
   output logic [4:0]        wb_addr,
   output logic [DATA_W-1:0] wb_data,
   output logic              done,
   output logic              err,
   output logic [1:0]        err_code
);
   typedef enum logic [2:0] {IDLE, ACCESS, WB, DONE, ERR} state_t;
   localparam logic [7:0] LAST = 8'(TIMEOUT - 1);
   state_t     state;
   logic [7:0] cnt;
   logic [4:0] rd_q;
   // every output is set on the transition into the state that owns it, so none depends on inputs combinationally
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         cnt      <= '0;
         rd_q     <= '0;
         ls_ready <= 1'b1;
         dm_req   <= 1'b0;
         dm_we    <= 1'b0;
         dm_addr  <= '0;
         dm_wdata <= '0;
         wb_en    <= 1'b0;
         wb_addr  <= '0;
         wb_data  <= '0;
         done     <= 1'b0;
         err      <= 1'b0;
         err_code <= '0;
      end else begin
         wb_en <= 1'b0;
         done  <= 1'b0;
         err   <= 1'b0;
         case (state)
            IDLE: if (ls_valid) begin
               dm_addr  <= alu_result;
               dm_wdata <= store_data;
               rd_q     <= rd_addr;
               cnt      <= '0;
               ls_ready <= 1'b0;
               if (alu_result[1:0] != 2'b00) begin
                  state    <= ERR;
                  err      <= 1'b1;
                  err_code <= 2'b01;
               end else begin
                  state    <= ACCESS;
                  dm_req   <= 1'b1;
                  dm_we    <= ls_is_store;
                  err_code <= 2'b00;
               end
            end
            ACCESS: if (dm_ack) begin
               dm_req <= 1'b0;
               dm_we  <= 1'b0;
               done   <= 1'b1;
               state  <= dm_we ? DONE : WB;
               if (!dm_we) begin
                  wb_en   <= 1'b1;
                  wb_addr <= rd_q;
                  wb_data <= dm_rdata;
               end
            end else if (cnt == LAST) begin
               dm_req   <= 1'b0;
               dm_we    <= 1'b0;
               err      <= 1'b1;
               err_code <= 2'b10;
               state    <= ERR;
            end else begin
               cnt <= cnt + 8'd1;
            end
            default: begin
               state    <= IDLE;
               ls_ready <= 1'b1;
            end
         endcase
      end
   end
endmodule

// File: doc/ls_ctrl12.md
# ls_ctrl12

Load/store sequencer sitting between the execute stage's 12-bit address ALU and the data memory port. It accepts one decoded load/store per transaction (address already computed as `alu_result`), checks word alignment, and drives a req/ack data-memory handshake with a bounded wait. It returns load data to the register file through a one-cycle write-back strobe and holds the pipeline via `ls_ready` while busy.

## Interface
- `DATA_W`, 32, data width of memory and register file
- `ADDR_W`, 12, byte address width; matches ALU result width
- `TIMEOUT`, 16, maximum number of cycles `dm_req` stays high waiting for `dm_ack`; legal range 1..255
- `clk`  in  1  single clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-low; all state and outputs clear immediately when low
- `ls_valid`  in  1  a load/store is presented this cycle
- `ls_is_store`  in  1  1 = store (SW/SWI), 0 = load (LW/LWI)
- `alu_result`  in  ADDR_W  byte address from the address ALU
- `store_data`  in  DATA_W  store data
- `rd_addr`  in  5  load destination register
- `ls_ready`  out  1  controller idle; a `ls_valid` in this cycle is accepted
- `dm_req`  out  1  memory request, held high until ack or timeout
- `dm_we`  out  1  write enable, valid while `dm_req`
- `dm_addr`  out  ADDR_W  latched address, stable while `dm_req`
- `dm_wdata`  out  DATA_W  latched store data, stable while `dm_req`
- `dm_ack`  in  1  memory completion; sampled only while `dm_req` = 1
- `dm_rdata`  in  DATA_W  load data, valid with `dm_ack`
- `wb_en`  out  1  one-cycle register write strobe
- `wb_addr`  out  5  write-back register
- `wb_data`  out  DATA_W  write-back data
- `done`  out  1  one-cycle pulse when a transaction finishes successfully
- `err`  out  1  one-cycle pulse on abort
- `err_code`  out  2  01 misaligned, 10 timeout; held until next accept

## Operation
- States: IDLE, ACCESS, WB, DONE, ERR. All outputs are registered or decoded from state only; no input-to-output combinational path.
- IDLE: `ls_ready` = 1. On `ls_valid`: latch address, store data, `rd_addr` and `ls_is_store`; clear `err_code`; clear wait counter. If `alu_result[1:0]` != 0, go to ERR with `err_code` = 01 and no memory access. Otherwise go to ACCESS.
- ACCESS: `dm_req` = 1 and `dm_we` = latched `ls_is_store`. Counter increments each cycle without ack.
  - Ack with a load: capture `dm_rdata`, go to WB.
  - Ack with a store: go to DONE.
  - No ack on the TIMEOUT-th cycle: go to ERR with `err_code` = 10. An ack on that same cycle wins over timeout.
- WB: `wb_en` = 1, `wb_addr` = latched rd, `wb_data` = captured data, `done` = 1. Next state IDLE.
- DONE: `done` = 1. Next state IDLE.
- ERR: `err` = 1. Next state IDLE.
- `dm_ack` outside ACCESS is ignored. `ls_valid` outside IDLE is ignored; upstream must hold it until `ls_ready`.
- Reset values: state IDLE, `ls_ready` = 1, every other output 0, including `dm_addr`, `dm_wdata`, `wb_*` and `err_code`.

## Timing
- Accept in cycle N (IDLE and `ls_valid`). `dm_req` is high from N+1.
- Ack sampled at the end of cycle A: `wb_en`/`done` are high in A+1, and `ls_ready` is high in A+2.
- Zero-wait memory (ack in N+1): `done` in N+2, next accept possible in N+3. Throughput is 1 op per 3 cycles.
- Misaligned access: `err` in N+1, `dm_req` never rises, `ls_ready` again in N+2.
- Timeout: `dm_req` is high for exactly TIMEOUT cycles (N+1..N+TIMEOUT), `err` in N+TIMEOUT+1, `ls_ready` in N+TIMEOUT+2.
- `reset` low mid-transaction: `dm_req`, `wb_en`, `done` and `err` drop asynchronously, and no write-back occurs. After release, the block is IDLE with `ls_ready` = 1 on the first edge.

## Test plan
- Load, address 0x104, `rd_addr` 5, ack in N+1 with `dm_rdata` 0xDEADBEEF -> `dm_req` in N+1 only with `dm_addr` = 0x104 and `dm_we` = 0; `wb_en` in N+2 with `wb_addr` 5 and `wb_data` 0xDEADBEEF; `done` in N+2; `ls_ready` in N+3.
- Store, address 0xFFC, data 0x12345678, ack delayed 3 cycles -> `dm_req`/`dm_we` high N+1..N+4 with `dm_wdata` stable; `done` N+5; `wb_en` never asserted.
- Load at address 0x102 -> `err` pulse N+1; `err_code` = 01 until the next accept; `dm_req` stays 0.
- TIMEOUT = 4, no ack -> `dm_req` high for exactly 4 cycles, then `err` with `err_code` = 10. Repeat with ack on the 4th cycle -> success, no `err`.
- Reset driven low 2 cycles into a load wait -> `dm_req` falls without a clock edge; no `wb_en`; after release a new store completes normally.
- Back-to-back ops with `ls_valid` held high -> second op accepted only when `ls_ready`; stray `dm_ack` in IDLE causes no output change.
